// File: rtl/cordic_arbiter_if.sv
// Requester-side bus of the shared CORDIC arbiter: request pulses and angles
// in, readiness, completion pulses and results out.
interface cordic_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_start;
    logic [NUM_REQ*16-1:0] req_angle;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_done;
    logic [15:0]           rsp_sin;
    logic [15:0]           rsp_cos;
    logic                  rsp_error;

    modport master (
        output req_start, req_angle,
        input  req_ready, rsp_done, rsp_sin, rsp_cos, rsp_error
    );

    modport slave (
        input  req_start, req_angle,
        output req_ready, rsp_done, rsp_sin, rsp_cos, rsp_error
    );
endinterface

// File: rtl/cordic_arbiter.sv
// Shares one cordic_core between NUM_REQ requesters. Each requester may hold
// one buffered request; the core is granted round-robin, and a watchdog
// aborts a grant whose core never reports done.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | core free; grant the next pending requester, if any
// S_WAIT | core running for grant_q; wait for done or watchdog expiry
module cordic_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    cordic_arbiter_if.slave     req_if,
    output logic                cordic_start_o,
    output logic [15:0]         cordic_angle_o,
    input  logic [15:0]         cordic_sin_i,
    input  logic [15:0]         cordic_cos_i,
    input  logic                cordic_done_i,
    output logic                busy_o
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] pending_q;
    logic [15:0]        angle_q [NUM_REQ];
    logic [GW-1:0]      last_grant_q;
    logic [GW-1:0]      grant_q;
    logic [TW-1:0]      timer_q;
    logic [NUM_REQ-1:0] rsp_done_q;
    logic [15:0]        rsp_sin_q;
    logic [15:0]        rsp_cos_q;
    logic               rsp_error_q;
    logic               start_q;
    logic [15:0]        cordic_angle_q;

    logic [NUM_REQ-1:0] ready_d;
    logic               pick_valid_d;
    logic [GW-1:0]      pick_d;
    int                 idx_d;

    // A requester is ready when it has nothing buffered and is not being served.
    always_comb begin
        ready_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ready_d[i] = ~pending_q[i] & ~((state_q == S_WAIT) && (grant_q == GW'(i)));
        end
    end

    // Round-robin pick: first pending index after last_grant_q. Scanning from the
    // far end down lets the nearest candidate overwrite the others.
    always_comb begin
        pick_valid_d = 1'b0;
        pick_d       = '0;
        idx_d        = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_d = (int'(last_grant_q) + k) % NUM_REQ;
            if (pending_q[idx_d]) begin
                pick_valid_d = 1'b1;
                pick_d       = GW'(idx_d);
            end
        end
    end

    // Request capture, grant/complete FSM, watchdog and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pending_q      <= '0;
            last_grant_q   <= GW'(NUM_REQ - 1);
            grant_q        <= '0;
            timer_q        <= '0;
            rsp_done_q     <= '0;
            rsp_sin_q      <= '0;
            rsp_cos_q      <= '0;
            rsp_error_q    <= 1'b0;
            start_q        <= 1'b0;
            cordic_angle_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                angle_q[i] <= '0;
            end
        end else begin
            start_q    <= 1'b0;
            rsp_done_q <= '0;

            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_if.req_start[i] && ready_d[i]) begin
                    pending_q[i] <= 1'b1;
                    angle_q[i]   <= req_if.req_angle[16*i +: 16];
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (pick_valid_d) begin
                        grant_q        <= pick_d;
                        last_grant_q   <= pick_d;
                        cordic_angle_q <= angle_q[pick_d];
                        start_q        <= 1'b1;
                        timer_q        <= '0;
                        state_q        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    if (cordic_done_i) begin
                        rsp_sin_q           <= cordic_sin_i;
                        rsp_cos_q           <= cordic_cos_i;
                        rsp_error_q         <= 1'b0;
                        rsp_done_q[grant_q] <= 1'b1;
                        pending_q[grant_q]  <= 1'b0;
                        state_q             <= S_IDLE;
                    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                        rsp_sin_q           <= '0;
                        rsp_cos_q           <= '0;
                        rsp_error_q         <= 1'b1;
                        rsp_done_q[grant_q] <= 1'b1;
                        pending_q[grant_q]  <= 1'b0;
                        state_q             <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_if.req_ready = ready_d;
    assign req_if.rsp_done  = rsp_done_q;
    assign req_if.rsp_sin   = rsp_sin_q;
    assign req_if.rsp_cos   = rsp_cos_q;
    assign req_if.rsp_error = rsp_error_q;
    assign cordic_start_o   = start_q;
    assign cordic_angle_o   = cordic_angle_q;
    assign busy_o           = (state_q == S_WAIT);
endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: a transaction-level model of the arbiter is
// compared against the DUT every cycle; directed scenarios add literal checks.
module tb_cordic_arbiter;
    localparam int N  = 3;
    localparam int TO = 64;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cordic_start;
    logic [15:0] cordic_angle;
    logic [15:0] cordic_sin  = 16'h0;
    logic [15:0] cordic_cos  = 16'h0;
    logic        cordic_done = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    cordic_arbiter_if #(.NUM_REQ(N)) req_if ();

    cordic_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_if         (req_if.slave),
        .cordic_start_o (cordic_start),
        .cordic_angle_o (cordic_angle),
        .cordic_sin_i   (cordic_sin),
        .cordic_cos_i   (cordic_cos),
        .cordic_done_i  (cordic_done),
        .busy_o         (busy)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- core model: fixed table of results -----------------
    function automatic logic [31:0] core_res(logic [15:0] a);
        case (a)
            16'h0000: return {16'h0000, 16'h4000};
            16'h2183: return {16'h2000, 16'h376D};
            16'h4305: return {16'h376D, 16'h2000};
            default:  return {a ^ 16'h5A5A, ~a};
        endcase
    endfunction

    int          core_lat = 18;   // 0 = core never answers
    int          core_cnt = 0;
    logic [15:0] core_ang = 16'h0;
    int          late_req = 0;
    int          late_ack = 0;

    always @(negedge clk) begin
        cordic_done = 1'b0;
        if (late_req != late_ack) begin
            cordic_done = 1'b1;
            late_ack    = late_req;
        end
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                cordic_done = 1'b1;
                {cordic_sin, cordic_cos} = core_res(core_ang);
            end
        end
        if (cordic_start && rst_n && core_lat > 0) begin
            core_cnt = core_lat;
            core_ang = cordic_angle;
        end
    end

    // ---------------- arbiter reference model -----------------
    bit          m_pend [N];
    logic [15:0] m_ang  [N];
    int          m_last = N - 1;
    int          m_cur  = -1;      // requester being served, -1 when core is free
    int          m_age  = 0;       // cycles the current grant has been waiting
    logic [N-1:0] m_rdy;
    logic         e_start = 1'b0;
    logic [15:0]  e_angle = 16'h0;
    logic [N-1:0] e_done  = '0;
    logic [15:0]  e_sin   = 16'h0;
    logic [15:0]  e_cos   = 16'h0;
    logic         e_err   = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_ang[i] = 16'h0; end
            m_last = N - 1; m_cur = -1; m_age = 0;
            e_start = 0; e_angle = 0; e_done = 0; e_sin = 0; e_cos = 0; e_err = 0;
        end else begin
            for (int i = 0; i < N; i++) m_rdy[i] = !m_pend[i] && (m_cur != i);
            e_start = 0;
            e_done  = '0;
            if (m_cur >= 0) begin
                m_age++;
                if (cordic_done) begin
                    e_done[m_cur] = 1'b1;
                    e_sin = cordic_sin; e_cos = cordic_cos; e_err = 1'b0;
                    m_pend[m_cur] = 0; m_cur = -1;
                end else if (m_age == TO) begin
                    e_done[m_cur] = 1'b1;
                    e_sin = 16'h0; e_cos = 16'h0; e_err = 1'b1;
                    m_pend[m_cur] = 0; m_cur = -1;
                end
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_last + k) % N;
                    if (m_pend[j]) begin
                        m_cur = j; m_last = j; m_age = 0;
                        e_start = 1'b1; e_angle = m_ang[j];
                        break;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_if.req_start[i] && m_rdy[i]) begin
                    m_pend[i] = 1;
                    m_ang[i]  = req_if.req_angle[16*i +: 16];
                end
            end
        end
    end

    // ---------------- compare + event log -----------------
    int          start_cyc_q[$];
    logic [15:0] start_ang_q[$];
    int          done_cyc_q[$];
    int          done_idx_q[$];
    logic [15:0] done_sin_q[$];
    logic [15:0] done_cos_q[$];
    logic        done_err_q[$];
    logic [N-1:0] c_rdy;

    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            for (int i = 0; i < N; i++) c_rdy[i] = !m_pend[i] && (m_cur != i);
            chk("req_ready",    32'(req_if.req_ready), 32'(c_rdy));
            chk("busy",         32'(busy),             32'(m_cur >= 0));
            chk("cordic_start", 32'(cordic_start),     32'(e_start));
            chk("cordic_angle", 32'(cordic_angle),     32'(e_angle));
            chk("rsp_done",     32'(req_if.rsp_done),  32'(e_done));
            chk("rsp_sin",      32'(req_if.rsp_sin),   32'(e_sin));
            chk("rsp_cos",      32'(req_if.rsp_cos),   32'(e_cos));
            chk("rsp_error",    32'(req_if.rsp_error), 32'(e_err));
            chk("done_onehot",  32'($countones(req_if.rsp_done) <= 1), 32'd1);
            if (cordic_start) begin
                start_cyc_q.push_back(cyc);
                start_ang_q.push_back(cordic_angle);
            end
            if (req_if.rsp_done != '0) begin
                int idx;
                idx = 0;
                for (int i = 0; i < N; i++) if (req_if.rsp_done[i]) idx = i;
                done_cyc_q.push_back(cyc);
                done_idx_q.push_back(idx);
                done_sin_q.push_back(req_if.rsp_sin);
                done_cos_q.push_back(req_if.rsp_cos);
                done_err_q.push_back(req_if.rsp_error);
            end
        end
    end

    // ---------------- stimulus -----------------
    task automatic issue(logic [N-1:0] mask, logic [15:0] a0, logic [15:0] a1, logic [15:0] a2);
        @(negedge clk);
        req_if.req_start = mask;
        req_if.req_angle = {a2, a1, a0};
        @(negedge clk);
        req_if.req_start = '0;
    endtask

    task automatic wait_resp(int target, int budget);
        int c;
        c = 0;
        while (done_idx_q.size() < target && c < budget) begin
            @(negedge clk); #1; c++;
        end
        chk("resp_arrived", 32'(done_idx_q.size() >= target), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int b, s, c;

    initial begin
        req_if.req_start = '0;
        req_if.req_angle = '0;
        #12;
        chk("rst_ready",  32'(req_if.req_ready), 32'h7);
        chk("rst_busy",   32'(busy),             32'h0);
        chk("rst_done",   32'(req_if.rsp_done),  32'h0);
        chk("rst_start",  32'(cordic_start),     32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single request
        b = done_idx_q.size(); s = start_cyc_q.size();
        issue(3'b001, 16'h2183, 16'h0, 16'h0);
        wait_resp(b + 1, 60);
        chk("single_angle", 32'(start_ang_q[s]), 32'h2183);
        chk("single_idx",   32'(done_idx_q[b]),  32'd0);
        chk("single_sin",   32'(done_sin_q[b]),  32'h2000);
        chk("single_cos",   32'(done_cos_q[b]),  32'h376D);
        chk("single_err",   32'(done_err_q[b]),  32'h0);
        chk("single_lat",   32'(done_cyc_q[b] - start_cyc_q[s]), 32'd19);
        chk("single_ready", 32'(req_if.req_ready[0]), 32'h1);

        // contention from a fresh reset
        do_reset();
        b = done_idx_q.size(); s = start_cyc_q.size();
        issue(3'b111, 16'h0000, 16'h2183, 16'h4305);
        wait_resp(b + 3, 120);
        chk("cont_idx0", 32'(done_idx_q[b]),     32'd0);
        chk("cont_idx1", 32'(done_idx_q[b + 1]), 32'd1);
        chk("cont_idx2", 32'(done_idx_q[b + 2]), 32'd2);
        chk("cont_sin0", 32'(done_sin_q[b]),     32'h0000);
        chk("cont_sin1", 32'(done_sin_q[b + 1]), 32'h2000);
        chk("cont_sin2", 32'(done_sin_q[b + 2]), 32'h376D);
        chk("cont_gap1", 32'(start_cyc_q[s + 1] - done_cyc_q[b]),     32'd1);
        chk("cont_gap2", 32'(start_cyc_q[s + 2] - done_cyc_q[b + 1]), 32'd1);

        // busy drop: requester 1 re-requests while still pending behind 0
        b = done_idx_q.size();
        issue(3'b011, 16'h0000, 16'h2183, 16'h0);
        issue(3'b010, 16'h0, 16'h1000, 16'h0);
        wait_resp(b + 2, 120);
        repeat (30) @(negedge clk);
        #1;
        chk("drop_count", 32'(done_idx_q.size() - b), 32'd2);
        chk("drop_idx",   32'(done_idx_q[b + 1]),     32'd1);
        chk("drop_sin",   32'(done_sin_q[b + 1]),     32'h2000);

        // round-robin: last served 1, requesters 0 and 2 pending
        b = done_idx_q.size();
        issue(3'b101, 16'h4305, 16'h0, 16'h0000);
        wait_resp(b + 2, 120);
        chk("rr_first",  32'(done_idx_q[b]),     32'd2);
        chk("rr_second", 32'(done_idx_q[b + 1]), 32'd0);
        chk("rr_sin0",   32'(done_sin_q[b + 1]), 32'h376D);

        // timeout: core silent for requester 1, late done in the idle cycle,
        // then requester 0 served normally
        b = done_idx_q.size(); s = start_cyc_q.size();
        core_lat = 0;
        issue(3'b011, 16'h2183, 16'h4305, 16'h0);
        c = 0;
        while (start_cyc_q.size() <= s && c < 20) begin @(negedge clk); #1; c++; end
        c = 0;
        while (cyc < start_cyc_q[s] + TO - 1 && c < 200) begin @(negedge clk); #1; c++; end
        late_req++;
        core_lat = 18;
        wait_resp(b + 2, 200);
        chk("to_idx",   32'(done_idx_q[b]), 32'd1);
        chk("to_err",   32'(done_err_q[b]), 32'h1);
        chk("to_sin",   32'(done_sin_q[b]), 32'h0);
        chk("to_cos",   32'(done_cos_q[b]), 32'h0);
        chk("to_lat",   32'(done_cyc_q[b] - start_cyc_q[s]), 32'd64);
        chk("to_next_idx", 32'(done_idx_q[b + 1]), 32'd0);
        chk("to_next_err", 32'(done_err_q[b + 1]), 32'h0);
        chk("to_next_sin", 32'(done_sin_q[b + 1]), 32'h2000);
        chk("to_next_lat", 32'(done_cyc_q[b + 1] - start_cyc_q[s + 1]), 32'd19);

        // async reset in the middle of a wait
        b = done_idx_q.size(); s = start_cyc_q.size();
        issue(3'b100, 16'h0, 16'h0, 16'h2183);
        c = 0;
        while (start_cyc_q.size() <= s && c < 20) begin @(negedge clk); #1; c++; end
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_busy",  32'(busy),              32'h0);
        chk("ar_ready", 32'(req_if.req_ready),  32'h7);
        chk("ar_angle", 32'(cordic_angle),      32'h0);
        chk("ar_sin",   32'(req_if.rsp_sin),    32'h0);
        chk("ar_cos",   32'(req_if.rsp_cos),    32'h0);
        chk("ar_done",  32'(req_if.rsp_done),   32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("ar_no_rsp", 32'(done_idx_q.size() - b), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
